// File: rtl/fmac_pkg.sv
// Shared definitions for the floating-point MAC sequencer.
//   EXP_W / MAN_W : float field widths (sign, 8-bit exponent, 24-bit mantissa)
//   fmac_float_t  : packed {sign, exp, man}
//   fmac_state_t  : sequencer states
//   is_zero()     : operand zero test (explicit leading one clear)
package fmac_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 24;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fmac_float_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fmac_state_t;

    function automatic logic is_zero(input logic [MAN_W-1:0] man);
        return ~man[MAN_W-1];
    endfunction

endpackage

// File: rtl/fmac_sequencer_if.sv
// Bundle of the sequencer's operand stream, MAC bus and result stream.
//   slave  : sequencer view (consumes operands, drives MAC, produces result)
//   master : environment view (produces operands, models MAC, consumes result)
interface fmac_sequencer_if
    import fmac_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) ();

    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic             in_as;
    logic [EXP_W-1:0] in_ae;
    logic [MAN_W-1:0] in_a;
    logic             in_bs;
    logic [EXP_W-1:0] in_be;
    logic [MAN_W-1:0] in_b;
    logic             in_last;

    // MAC operands, accumulator and result
    logic             mac_as;
    logic [EXP_W-1:0] mac_ae;
    logic [MAN_W-1:0] mac_a;
    logic             mac_bs;
    logic [EXP_W-1:0] mac_be;
    logic [MAN_W-1:0] mac_b;
    logic             mac_ps;
    logic [EXP_W-1:0] mac_pe;
    logic [MAN_W-1:0] mac_p;
    logic             mac_nps;
    logic [EXP_W-1:0] mac_npe;
    logic [MAN_W-1:0] mac_np;

    // Result stream
    logic             out_valid;
    logic             out_ready;
    logic             out_s;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_m;
    logic [LEN_W-1:0] out_count;

    modport slave (
        input  in_valid, in_as, in_ae, in_a, in_bs, in_be, in_b, in_last,
        output in_ready,
        output mac_as, mac_ae, mac_a, mac_bs, mac_be, mac_b,
        output mac_ps, mac_pe, mac_p,
        input  mac_nps, mac_npe, mac_np,
        output out_valid, out_s, out_e, out_m, out_count,
        input  out_ready
    );

    modport master (
        output in_valid, in_as, in_ae, in_a, in_bs, in_be, in_b, in_last,
        input  in_ready,
        input  mac_as, mac_ae, mac_a, mac_bs, mac_be, mac_b,
        input  mac_ps, mac_pe, mac_p,
        output mac_nps, mac_npe, mac_np,
        input  out_valid, out_s, out_e, out_m, out_count,
        output out_ready
    );

endinterface

// File: rtl/fmac_wait_cnt.sv
// Loadable down-counter timing the MAC settling latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load MAC_LAT-1 (takes priority over dec_i)
//   dec_i      : decrement, holding at zero
//   zero_o     : counter is zero
module fmac_wait_cnt #(
    parameter int unsigned MAC_LAT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [7:0] LOAD_VAL = 8'(MAC_LAT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fmac_sequencer.sv
// Sequencer for the booth_float_ext multiply-accumulate unit. Accepts operand
// pairs, drives them to the MAC, waits MAC_LAT cycles per nonzero pair, feeds
// the MAC result back as the accumulator and presents the final sum.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : operand stream (in_*), MAC bus (mac_*), result stream (out_*)
module fmac_sequencer
    import fmac_pkg::*;
#(
    parameter int unsigned MAC_LAT = 15,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    fmac_sequencer_if.slave  bus
);

    fmac_state_t      state_q;
    fmac_float_t      a_q;
    fmac_float_t      b_q;
    fmac_float_t      acc_q;
    logic             last_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    logic accept;
    logic op_zero;
    logic wait_load;
    logic wait_dec;
    logic wait_zero;

    assign accept    = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign op_zero   = is_zero(bus.in_a) || is_zero(bus.in_b);
    assign count_d   = (count_q == '1) ? count_q : count_q + LEN_W'(1);
    assign wait_load = accept && !op_zero;
    assign wait_dec  = (state_q == WAIT);

    fmac_wait_cnt #(
        .MAC_LAT (MAC_LAT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (wait_load),
        .dec_i  (wait_dec),
        .zero_o (wait_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= '{sign: bus.in_as, exp: bus.in_ae, man: bus.in_a};
                        b_q     <= '{sign: bus.in_bs, exp: bus.in_be, man: bus.in_b};
                        last_q  <= bus.in_last;
                        count_q <= count_d;
                        // A zero pair leaves the accumulator alone and skips the MAC wait.
                        if (op_zero) begin
                            if (bus.in_last) begin
                                state_q     <= DONE;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q    <= WAIT;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_zero) begin
                        acc_q <= '{sign: bus.mac_nps, exp: bus.mac_npe, man: bus.mac_np};
                        if (last_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        count_q     <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mac_as    = a_q.sign;
    assign bus.mac_ae    = a_q.exp;
    assign bus.mac_a     = a_q.man;
    assign bus.mac_bs    = b_q.sign;
    assign bus.mac_be    = b_q.exp;
    assign bus.mac_b     = b_q.man;
    assign bus.mac_ps    = acc_q.sign;
    assign bus.mac_pe    = acc_q.exp;
    assign bus.mac_p     = acc_q.man;
    // The final sum is the accumulator itself; it only leaves through out_* in DONE.
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = acc_q.sign;
    assign bus.out_e     = acc_q.exp;
    assign bus.out_m     = acc_q.man;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_fmac_sequencer.sv
module tb_fmac_sequencer;

    localparam int unsigned LAT = 15;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   mode = 0;
    int   age = 0;
    logic [98:0] snap_v = '0;
    logic [98:0] cur_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fmac_sequencer_if #(.LEN_W(8)) bus ();
    fmac_sequencer_if #(.LEN_W(2)) sbus ();

    fmac_sequencer #(.MAC_LAT(LAT), .LEN_W(8)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    fmac_sequencer #(.MAC_LAT(2), .LEN_W(2)) u_sat (.clk(clk), .reset(reset), .bus(sbus));

    // Arbitrary deterministic MAC function used by the randomized sums.
    function automatic logic [32:0] mac_fn(input logic [32:0] p, input logic [32:0] a,
                                           input logic [32:0] b);
        logic [32:0] r;
        r[32]    = p[32] ^ a[32] ^ b[32];
        r[31:24] = p[31:24] + a[31:24] - b[31:24];
        r[23:0]  = (p[23:0] ^ a[23:0]) + b[23:0];
        return r;
    endfunction

    function automatic logic [32:0] fl(input logic s, input logic [7:0] e, input logic [23:0] m);
        return {s, e, m};
    endfunction

    // MAC model: result is garbage until the inputs have been stable LAT cycles.
    always @(negedge clk) begin
        cur_v = {bus.mac_as, bus.mac_ae, bus.mac_a, bus.mac_bs, bus.mac_be, bus.mac_b,
                 bus.mac_ps, bus.mac_pe, bus.mac_p};
        if (cur_v !== snap_v) age = 1;
        else if (age < 1000) age++;
        snap_v = cur_v;
        if (age >= int'(LAT)) begin
            case (mode)
                0: {bus.mac_nps, bus.mac_npe, bus.mac_np} = {1'b0, 8'h81, 24'hC00000};
                1: {bus.mac_nps, bus.mac_npe, bus.mac_np} = {bus.mac_ps, bus.mac_pe, bus.mac_p + 24'd1};
                default: {bus.mac_nps, bus.mac_npe, bus.mac_np} =
                    mac_fn({bus.mac_ps, bus.mac_pe, bus.mac_p},
                           {bus.mac_as, bus.mac_ae, bus.mac_a},
                           {bus.mac_bs, bus.mac_be, bus.mac_b});
            endcase
        end else begin
            {bus.mac_nps, bus.mac_npe, bus.mac_np} = {1'b1, 8'hA5, 24'h5A5A5A};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [32:0] a, input logic [32:0] b, input logic last, output int k);
        int n = 0;
        @(negedge clk);
        {bus.in_as, bus.in_ae, bus.in_a} = a;
        {bus.in_bs, bus.in_be, bus.in_b} = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        k = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [23:0] am, input logic last);
        int n = 0;
        @(negedge clk);
        sbus.in_a    = am;
        sbus.in_b    = 24'h800000;
        sbus.in_last = last;
        sbus.in_valid = 1'b1;
        while (!sbus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sat_accept_in_time", 64'(sbus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drain_out_valid", 64'(bus.out_valid), 64'(0));
        check("drain_in_ready", 64'(bus.in_ready), 64'(1));
        check("drain_mac_p", 64'(bus.mac_p), 64'(0));
        check("drain_count", 64'(bus.out_count), 64'(0));
    endtask

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        int          lat;
        logic [23:0] m;
        logic [7:0]  e;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k0, k1, k2, lat, n;
        logic [32:0] a, b, acc;
        logic [63:0] hold;
        logic [23:0] m;

        tbl[0] = '{24'h800000, 24'h800000, 15, 24'hC00000, 8'h81};
        tbl[1] = '{24'h7FFFFF, 24'h800000, 0,  24'h000000, 8'h00};
        tbl[2] = '{24'h800000, 24'h000000, 0,  24'h000000, 8'h00};
        tbl[3] = '{24'hFFFFFF, 24'hFFFFFF, 15, 24'hC00000, 8'h81};
        tbl[4] = '{24'h000000, 24'h000000, 0,  24'h000000, 8'h00};
        tbl[5] = '{24'hC00001, 24'h400000, 0,  24'h000000, 8'h00};

        reset = 1'b0;
        {bus.in_valid, bus.in_as, bus.in_ae, bus.in_a, bus.in_bs, bus.in_be, bus.in_b, bus.in_last} = '0;
        bus.out_ready = 1'b0;
        {sbus.in_valid, sbus.in_as, sbus.in_ae, sbus.in_a, sbus.in_bs, sbus.in_be, sbus.in_b, sbus.in_last} = '0;
        {sbus.mac_nps, sbus.mac_npe, sbus.mac_np} = '0;
        sbus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out", 64'({bus.out_valid, bus.out_count, bus.out_s, bus.out_e, bus.out_m}), 64'(0));
        check("reset_mac_a", 64'({bus.mac_as, bus.mac_ae, bus.mac_a}), 64'(0));
        check("reset_mac_b", 64'({bus.mac_bs, bus.mac_be, bus.mac_b}), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single-pair table: latency and result for nonzero vs zero operands.
        mode = 0;
        foreach (tbl[i]) begin
            send(fl(1'b0, 8'h80, tbl[i].a), fl(1'b0, 8'h7F, tbl[i].b), 1'b1, k);
            wait_valid(lat);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("tbl%0d_out_m", i), 64'(bus.out_m), 64'(tbl[i].m));
            check($sformatf("tbl%0d_out_e", i), 64'(bus.out_e), 64'(tbl[i].e));
            check($sformatf("tbl%0d_out_s", i), 64'(bus.out_s), 64'(0));
            check($sformatf("tbl%0d_count", i), 64'(bus.out_count), 64'(1));
            drain();
        end

        // Reset mid-WAIT.
        mode = 1;
        send(fl(1'b1, 8'h10, 24'h800001), fl(1'b0, 8'h20, 24'h900000), 1'b0, k);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_mac_a", 64'({bus.mac_as, bus.mac_ae, bus.mac_a}), 64'(0));
        check("rst_mid_mac_b", 64'({bus.mac_bs, bus.mac_be, bus.mac_b}), 64'(0));
        check("rst_mid_acc", 64'({bus.mac_ps, bus.mac_pe, bus.mac_p}), 64'(0));
        check("rst_mid_out", 64'({bus.out_valid, bus.out_count}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", 64'(bus.in_ready), 64'(1));
        send(fl(1'b0, 8'h01, 24'h800000), fl(1'b0, 8'h02, 24'h800000), 1'b1, k);
        wait_valid(lat);
        check("rst_new_sum_m", 64'(bus.out_m), 64'(1));
        check("rst_new_sum_count", 64'(bus.out_count), 64'(1));
        drain();

        // Accumulator feedback: three pairs, p increments each element.
        k0 = 0;
        for (int i = 0; i < 3; i++) begin
            send(fl(1'b0, 8'h40, 24'h812345), fl(1'b1, 8'h41, 24'hA00000), (i == 2), k);
            check($sformatf("fb_mac_p%0d", i), 64'(bus.mac_p), 64'(i));
            if (i > 0) check($sformatf("fb_spacing%0d", i), 64'(k - k0), 64'(LAT + 1));
            k0 = k;
        end
        wait_valid(lat);
        check("fb_latency", 64'(lat), 64'(LAT));
        check("fb_out_m", 64'(bus.out_m), 64'(3));
        check("fb_count", 64'(bus.out_count), 64'(3));
        drain();

        // Zero operand in the middle of a sum.
        send(fl(1'b0, 8'h40, 24'h800000), fl(1'b0, 8'h40, 24'h800000), 1'b0, k0);
        send(fl(1'b0, 8'h40, 24'h800000), fl(1'b0, 8'h00, 24'h000000), 1'b0, k1);
        check("zero_spacing_before", 64'(k1 - k0), 64'(LAT + 1));
        check("zero_in_ready_next", 64'(bus.in_ready), 64'(1));
        check("zero_mac_p", 64'(bus.mac_p), 64'(1));
        check("zero_count", 64'(bus.out_count), 64'(2));
        send(fl(1'b0, 8'h40, 24'h800000), fl(1'b0, 8'h40, 24'h800000), 1'b1, k2);
        check("zero_spacing_after", 64'(k2 - k1), 64'(1));
        wait_valid(lat);
        check("zero_out_m", 64'(bus.out_m), 64'(2));
        check("zero_out_count", 64'(bus.out_count), 64'(3));

        // Result backpressure, with a pending operand that must be ignored.
        hold = 64'({bus.out_s, bus.out_e, bus.out_m, bus.out_count});
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d", i),
                  64'({bus.out_valid, bus.in_ready, bus.out_s, bus.out_e, bus.out_m, bus.out_count}),
                  {hold[63:42], 2'b10, hold[40:0]});
        end
        bus.in_valid = 1'b0;
        drain();

        // Randomized sums against the reference fold.
        mode = 2;
        for (int t = 0; t < 25; t++) begin
            n = int'($urandom_range(1, 5));
            acc = '0;
            for (int j = 0; j < n; j++) begin
                m = 24'($urandom);
                m[23] = ($urandom_range(0, 3) != 0);
                a = fl(1'($urandom), 8'($urandom), m);
                m = 24'($urandom);
                m[23] = ($urandom_range(0, 3) != 0);
                b = fl(1'($urandom), 8'($urandom), m);
                send(a, b, (j == n - 1), k);
                check("rnd_mac_a", 64'({bus.mac_as, bus.mac_ae, bus.mac_a}), 64'(a));
                check("rnd_mac_b", 64'({bus.mac_bs, bus.mac_be, bus.mac_b}), 64'(b));
                if (a[23] && b[23]) acc = mac_fn(acc, a, b);
            end
            wait_valid(lat);
            check("rnd_out_valid", 64'(bus.out_valid), 64'(1));
            check("rnd_sum", 64'({bus.out_s, bus.out_e, bus.out_m}), 64'(acc));
            check("rnd_count", 64'(bus.out_count), 64'(n));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rnd_held", 64'({bus.out_valid, bus.out_s, bus.out_e, bus.out_m}), 64'({1'b1, acc}));
            drain();
        end

        // Counter saturation with a 2-bit count.
        send_s(24'h000000, 1'b0);
        send_s(24'h800000, 1'b0);
        send_s(24'h000000, 1'b0);
        send_s(24'h900000, 1'b0);
        send_s(24'h000000, 1'b1);
        check("sat_out_valid", 64'(sbus.out_valid), 64'(1));
        check("sat_count", 64'(sbus.out_count), 64'(3));
        sbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sbus.out_ready = 1'b0;
        check("sat_drain_count", 64'(sbus.out_count), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fmac_sequencer.md
# fmac_sequencer

Hardware controller for the `booth_float_ext` floating-point multiply-accumulate unit. It accepts a stream of operand pairs over a valid/ready handshake and drives them onto the MAC inputs. For each pair it waits the MAC settling latency, then feeds the MAC result back as the next accumulator input. When the pair flagged last has been accumulated, it presents the final sum on a valid/ready result port. Number format on every float port: sign bit, 8-bit exponent, 24-bit mantissa with an explicit leading one (MSB = 1 for nonzero values).

## Interface
- `MAC_LAT`, default 15: cycles from MAC input change to a stable MAC result. Legal range 1..255.
- `LEN_W`, default 8: width of the accumulated-element counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block accepts a pair this cycle.
- `in_as`, `in_bs` in 1 each: operand signs.
- `in_ae`, `in_be` in 8 each: operand exponents.
- `in_a`, `in_b` in 24 each: operand mantissas.
- `in_last` in 1: this pair ends the accumulation.
- `mac_as`, `mac_ae`, `mac_a`, `mac_bs`, `mac_be`, `mac_b` out 1/8/24 each: registered operands to the MAC.
- `mac_ps`, `mac_pe`, `mac_p` out 1/8/24: registered accumulator to the MAC.
- `mac_nps`, `mac_npe`, `mac_np` in 1/8/24: MAC result.
- `out_valid` out 1: final sum available.
- `out_ready` in 1: consumer takes the sum.
- `out_s`, `out_e`, `out_m` out 1/8/24: final sum. Equal to `mac_ps`, `mac_pe`, `mac_p` while `out_valid` is high.
- `out_count` out LEN_W: number of pairs accumulated.

## Operation
- States: IDLE, WAIT, DONE.
- Reset values:
  - State is IDLE.
  - All `mac_*` outputs are 0 and the accumulator is 0.
  - `out_valid` = 0 and `out_count` = 0.
  - `in_ready` = 1.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, register all operand fields into `mac_*` operand outputs, latch `in_last`, and increment the counter (saturating at 2^LEN_W − 1).
  - If either mantissa MSB is 0, the operand is zero: the accumulator is unchanged and the MAC is not waited on. Go to DONE if last, otherwise stay in IDLE.
  - Otherwise load the wait counter with MAC_LAT−1 and go to WAIT.
- WAIT:
  - `in_ready` = 0.
  - Decrement the wait counter each cycle.
  - When it reaches 0, capture `mac_nps`/`mac_npe`/`mac_np` into the accumulator registers (`mac_ps`/`mac_pe`/`mac_p`).
  - Then go to DONE if last, otherwise to IDLE.
- DONE:
  - `out_valid` = 1 and `in_ready` = 0.
  - Outputs are held stable until `out_ready`.
  - On `out_ready`: clear the accumulator, clear `out_count`, and go to IDLE. The next accepted pair starts a new sum from 0.
- Operands registered into `mac_*` hold their value until the next accept. They are not cleared by DONE.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- Reset asserted mid-operation: immediate return to reset values. The partial sum and count are discarded.

## Timing
- Accept at edge k. MAC operand inputs are valid from edge k. The result is captured at edge k+MAC_LAT.
- `in_ready` is high again in the cycle after capture. The earliest next accept is edge k+MAC_LAT+1, so the element period is MAC_LAT+1 cycles.
- Zero-operand pair: 1-cycle element period, no wait.
- Last pair: `out_valid` rises at the capture edge (k+MAC_LAT), or at edge k for a zero pair.
- `out_valid` falls at the edge where `out_ready` is sampled high. `in_ready` rises at that same edge.
- All outputs are registered. There is no combinational path from `in_*`, `out_ready` or `mac_n*` to any output.

## Structure
- Shared package `fmac_pkg` holds:
  - Float field widths: EXP_W = 8, MAN_W = 24.
  - A packed float struct/typedef {sign, exp, man}.
  - The state enum {IDLE, WAIT, DONE}.
  - The zero test: mantissa MSB == 0.
- One natural sub-module, `fmac_wait_cnt`: a loadable down-counter with a zero flag, parameterised by MAC_LAT. Everything else is the FSM plus registers in `fmac_sequencer`.

## Test plan
- **Reset mid-WAIT:** assert reset 3 cycles after an accept. Required response:
  - All outputs read 0 immediately.
  - `in_ready` = 1 after release.
  - A new single pair sums from 0.
- **Single-pair latency:** a behavioral MAC model returns np = 24'hC00000, npe = 8'h81, nps = 0. Send one pair with `in_last` = 1. Required response:
  - `out_valid` rises exactly MAC_LAT = 15 cycles after the accept.
  - `out_m` = 24'hC00000, `out_e` = 8'h81, `out_count` = 1.
- **Accumulator feedback:** three pairs, last on the third; the model returns np = p + 1 on the mantissa, starting from p = 0. Required response:
  - `mac_p` = 0, 1, 2 at the three accepts.
  - Final `out_m` = 3 and `out_count` = 3.
  - Accepts are spaced by ≥ 16 cycles.
- **Zero operand:** second pair has `in_b` = 24'h000000, `in_be` = 0. Required response:
  - No wait.
  - `in_ready` is high the next cycle.
  - `mac_p` is unchanged and `out_count` still increments.
- **Result backpressure:** hold `out_ready` = 0 for 10 cycles in DONE. Required response:
  - `out_*` are stable and `in_ready` = 0 throughout.
  - On `out_ready` = 1: IDLE, and `mac_p` = 0 next cycle.
- **Saturation:** LEN_W = 2, five pairs. Required response: `out_count` = 3.
